// File: rtl/display_output_if.sv
// Bus between the control unit and the display output stage.
// Carries the capture strobe, LED/digit data and the registered board-side outputs.
// No backpressure: the control unit drives, the output stage always accepts.
// Ports (signals): load, led_red, led_green, led_red_blink, hex_code, hex_off,
//   hex_blink, lz_en, [brightness when DISPLAY_OUTPUT_DIM_EN], LR, LG, HEX, blink_phase.
// master = control side (drives data, reads outputs); slave = display_output_unit.
interface display_output_if #(
  parameter int NUM_DIGITS = 4,
  parameter int LEDR_W     = 10,
  parameter int LEDG_W     = 8
);
  logic                    load;
  logic [LEDR_W-1:0]       led_red;
  logic [LEDG_W-1:0]       led_green;
  logic [LEDR_W-1:0]       led_red_blink;
  logic [4*NUM_DIGITS-1:0] hex_code;
  logic [NUM_DIGITS-1:0]   hex_off;
  logic [NUM_DIGITS-1:0]   hex_blink;
  logic                    lz_en;
`ifdef DISPLAY_OUTPUT_DIM_EN
  logic [3:0]              brightness;
`endif
  logic [LEDR_W-1:0]       LR;
  logic [LEDG_W-1:0]       LG;
  logic [7*NUM_DIGITS-1:0] HEX;
  logic                    blink_phase;

  modport master (
`ifdef DISPLAY_OUTPUT_DIM_EN
    output brightness,
`endif
    output load, led_red, led_green, led_red_blink, hex_code, hex_off, hex_blink, lz_en,
    input  LR, LG, HEX, blink_phase
  );

  modport slave (
`ifdef DISPLAY_OUTPUT_DIM_EN
    input  brightness,
`endif
    input  load, led_red, led_green, led_red_blink, hex_code, hex_off, hex_blink, lz_en,
    output LR, LG, HEX, blink_phase
  );
endinterface

// File: rtl/display_output_unit.sv
// Board output stage: double-buffered LED banks and active-low 7-segment digits
// with per-bit/per-digit blinking and leading-zero suppression.
// Latency: load captured at edge N appears on the outputs at edge N+1. No backpressure.
// Ports: clk, rst_n (async active-low), bus (display_output_if.slave): data inputs
//   captured on load, registered outputs LR, LG, HEX, blink_phase.
// Optional: define DISPLAY_OUTPUT_DIM_EN to add a 4-bit brightness input and PWM dimming.
module display_output_unit #(
  parameter int NUM_DIGITS = 4,
  parameter int LEDR_W     = 10,
  parameter int LEDG_W     = 8,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  display_output_if.slave bus
);

  localparam int            CW         = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);

  // Active-low glyphs, bit0 = segment a ... bit6 = segment g.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Shadow registers
  logic [LEDR_W-1:0]       red_q;
  logic [LEDG_W-1:0]       green_q;
  logic [LEDR_W-1:0]       red_blink_q;
  logic [4*NUM_DIGITS-1:0] code_q;
  logic [NUM_DIGITS-1:0]   off_q;
  logic [NUM_DIGITS-1:0]   hblink_q;
  logic                    lz_q;
`ifdef DISPLAY_OUTPUT_DIM_EN
  logic [3:0]              bright_q;
  logic [3:0]              pwm_q;
`endif

  // Blink timebase
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          wrap;

  // Output registers
  logic [LEDR_W-1:0]       lr_q, lr_d;
  logic [LEDG_W-1:0]       lg_q, lg_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_q       <= '0;
      green_q     <= '0;
      red_blink_q <= '0;
      code_q      <= '0;
      off_q       <= '1;
      hblink_q    <= '0;
      lz_q        <= 1'b0;
`ifdef DISPLAY_OUTPUT_DIM_EN
      bright_q    <= 4'hF;
`endif
    end else if (bus.load) begin
      red_q       <= bus.led_red;
      green_q     <= bus.led_green;
      red_blink_q <= bus.led_red_blink;
      code_q      <= bus.hex_code;
      off_q       <= bus.hex_off;
      hblink_q    <= bus.hex_blink;
      lz_q        <= bus.lz_en;
`ifdef DISPLAY_OUTPUT_DIM_EN
      bright_q    <= bus.brightness;
`endif
    end
  end

  assign wrap    = (cnt_q == BLINK_LAST);
  assign cnt_d   = wrap ? '0 : cnt_q + 1'b1;
  assign phase_d = phase_q ^ wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
`ifdef DISPLAY_OUTPUT_DIM_EN
      pwm_q   <= 4'h0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
`ifdef DISPLAY_OUTPUT_DIM_EN
      pwm_q   <= pwm_q + 4'h1;
`endif
    end
  end

  // Decode from shadows and the current phase; the result is registered once.
  always_comb begin
    logic       above_clear;
    logic       blank;
    logic [3:0] digit;
    lr_d        = red_q & ~(red_blink_q & {LEDR_W{phase_q}});
    lg_d        = green_q;
    hex_d       = '1;
    above_clear = 1'b1;
    blank       = 1'b0;
    digit       = 4'h0;
    // Walk from the most significant digit down. above_clear stays set while
    // every digit seen so far is zero or forced off, so an off digit does not
    // end suppression but any visible non-zero digit does.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      digit = code_q[4*i +: 4];
      blank = off_q[i] | (hblink_q[i] & phase_q);
      if ((i > 0) && lz_q && (digit == 4'h0) && above_clear) begin
        blank = 1'b1;
      end
      above_clear = above_clear & ((digit == 4'h0) | off_q[i]);
      hex_d[7*i +: 7] = blank ? 7'h7F : seg_decode(digit);
    end
`ifdef DISPLAY_OUTPUT_DIM_EN
    // Full scale bypasses the PWM so brightness F is steady rather than 15/16.
    if (!((bright_q == 4'hF) || (pwm_q < bright_q))) begin
      lr_d  = '0;
      lg_d  = '0;
      hex_d = '1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lr_q  <= '0;
      lg_q  <= '0;
      hex_q <= '1;
    end else begin
      lr_q  <= lr_d;
      lg_q  <= lg_d;
      hex_q <= hex_d;
    end
  end

  assign bus.LR          = lr_q;
  assign bus.LG          = lg_q;
  assign bus.HEX         = hex_q;
  assign bus.blink_phase = phase_q;

endmodule

// File: tb/tb_display_output_unit.sv
module tb_display_output_unit;

  localparam int BD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  typedef struct {
    int          cyc;
    logic [9:0]  lr;
    logic [7:0]  lg;
    logic [27:0] hex;
    logic        ph;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  display_output_if #(.NUM_DIGITS(4), .LEDR_W(10), .LEDG_W(8)) bus ();

  display_output_unit #(.NUM_DIGITS(4), .LEDR_W(10), .LEDG_W(8), .BLINK_DIV(BD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Edges since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Blink phase held after edge c.
  function automatic logic ph_after(input int c);
    return ((c / BD) % 2) == 1;
  endfunction

  function automatic logic [27:0] h4(input logic [6:0] d3, input logic [6:0] d2,
                                     input logic [6:0] d1, input logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic expect_at(input int c, input logic [9:0] lr, input logic [7:0] lg,
                           input logic [27:0] hex, input string nm);
    exp_t e;
    e.cyc = c; e.lr = lr; e.lg = lg; e.hex = hex; e.ph = ph_after(c);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compares the DUT against the head of the queue on the cycle it is due.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (exp_q.size() > 0) begin
      if (exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", nm, e.cyc, cyc);
      end else if (exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        vectors++;
        if (bus.LR !== e.lr || bus.LG !== e.lg || bus.HEX !== e.hex || bus.blink_phase !== e.ph) begin
          miscompares++;
          $display("FAIL %s cyc=%0d: got LR=%h LG=%h HEX=%h ph=%b, want LR=%h LG=%h HEX=%h ph=%b",
                   nm, cyc, bus.LR, bus.LG, bus.HEX, bus.blink_phase, e.lr, e.lg, e.hex, e.ph);
        end
      end
    end
  end

  // One-cycle load pulse; c is the edge count before the capturing edge.
  task automatic apply(input logic [9:0] r, input logic [9:0] rb, input logic [7:0] g,
                       input logic [15:0] code, input logic [3:0] off, input logic [3:0] hb,
                       input logic lz, output int c);
    @(negedge clk);
    bus.led_red = r; bus.led_red_blink = rb; bus.led_green = g;
    bus.hex_code = code; bus.hex_off = off; bus.hex_blink = hb; bus.lz_en = lz;
    bus.load = 1'b1;
    c = cyc;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: %0d expectations still pending after timeout", nm, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  initial begin
    int c;
    logic ph;
    bus.load = 1'b0;
    bus.led_red = '0; bus.led_red_blink = '0; bus.led_green = '0;
    bus.hex_code = '0; bus.hex_off = '0; bus.hex_blink = '0; bus.lz_en = 1'b0;
`ifdef DISPLAY_OUTPUT_DIM_EN
    bus.brightness = 4'hF;
`endif

    // Reset state, then idle until the first phase toggle.
    expect_at(0, 10'h000, 8'h00, 28'hFFFFFFF, "reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_at(3, 10'h000, 8'h00, 28'hFFFFFFF, "idle_pre_wrap");
    expect_at(4, 10'h000, 8'h00, 28'hFFFFFFF, "idle_phase1");
    repeat (6) @(negedge clk);

    apply(10'h2A5, 10'h000, 8'h5A, 16'h1A3F, 4'h0, 4'h0, 1'b0, c);
    expect_at(c + 2, 10'h2A5, 8'h5A, h4(7'h79, 7'h08, 7'h30, 7'h0E), "glyph_1A3F");

    apply(10'h155, 10'h000, 8'hC3, 16'h0070, 4'h0, 4'h0, 1'b1, c);
    expect_at(c + 2, 10'h155, 8'hC3, h4(7'h7F, 7'h7F, 7'h78, 7'h40), "lz_0070");

    apply(10'h155, 10'h000, 8'hC3, 16'h0000, 4'h0, 4'h0, 1'b1, c);
    expect_at(c + 2, 10'h155, 8'hC3, h4(7'h7F, 7'h7F, 7'h7F, 7'h40), "lz_0000");

    apply(10'h001, 10'h000, 8'h01, 16'h0000, 4'h0, 4'h0, 1'b0, c);
    expect_at(c + 2, 10'h001, 8'h01, h4(7'h40, 7'h40, 7'h40, 7'h40), "nolz_0000");

    apply(10'h001, 10'h000, 8'h01, 16'h5002, 4'h8, 4'h0, 1'b1, c);
    expect_at(c + 2, 10'h001, 8'h01, h4(7'h7F, 7'h7F, 7'h7F, 7'h24), "lz_off_above");

    apply(10'h001, 10'h000, 8'h01, 16'h0102, 4'h0, 4'h0, 1'b1, c);
    expect_at(c + 2, 10'h001, 8'h01, h4(7'h7F, 7'h79, 7'h40, 7'h24), "lz_stop_0102");

    apply(10'h0F0, 10'h000, 8'h3C, 16'h96BD, 4'h4, 4'h0, 1'b0, c);
    expect_at(c + 2, 10'h0F0, 8'h3C, h4(7'h10, 7'h7F, 7'h03, 7'h21), "glyph_96BD_off2");

    // Inputs change without load: outputs hold.
    @(negedge clk);
    bus.led_red = 10'h3FF; bus.led_green = 8'hFF; bus.hex_code = 16'h1111;
    bus.hex_off = 4'h0; bus.lz_en = 1'b1;
    c = cyc;
    for (int k = 1; k <= 3; k++)
      expect_at(c + k, 10'h0F0, 8'h3C, h4(7'h10, 7'h7F, 7'h03, 7'h21), "hold_no_load");
    repeat (4) @(negedge clk);

    // Load held on two consecutive edges.
    @(negedge clk);
    bus.led_red = 10'h3C0; bus.led_red_blink = '0; bus.led_green = 8'h0F;
    bus.hex_code = 16'h7654; bus.hex_off = 4'h0; bus.hex_blink = 4'h0; bus.lz_en = 1'b0;
    bus.load = 1'b1;
    c = cyc;
    @(negedge clk);
    bus.led_red = 10'h003; bus.led_green = 8'hF0; bus.hex_code = 16'hE0C8; bus.lz_en = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    expect_at(c + 2, 10'h3C0, 8'h0F, h4(7'h78, 7'h02, 7'h12, 7'h19), "cont_load_a");
    expect_at(c + 3, 10'h003, 8'hF0, h4(7'h06, 7'h40, 7'h46, 7'h00), "cont_load_b");

    // Blinking: LR bit0 and digit0 follow the phase held before each edge.
    apply(10'h3FF, 10'h001, 8'h81, 16'h0008, 4'h0, 4'h1, 1'b0, c);
    for (int k = c + 2; k <= c + 13; k++) begin
      ph = ph_after(k - 1);
      expect_at(k, ph ? 10'h3FE : 10'h3FF, 8'h81,
                h4(7'h40, 7'h40, 7'h40, ph ? 7'h7F : 7'h00), "blink");
    end
    drain("blink_drain");

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #2 rst_n = 1'b0;
    expect_at(0, 10'h000, 8'h00, 28'hFFFFFFF, "async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_at(2, 10'h000, 8'h00, 28'hFFFFFFF, "after_reset_shadow");
    drain("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_output_unit.md
Name: display_output_unit

Overview:
- Parametrised successor to the board output stage. Drives red/green LED banks and NUM_DIGITS active-low 7-segment digits from one clock.
- Adds double-buffered shadow registers loaded on a strobe, per-digit and per-LED blinking, and leading-zero suppression.
- Sits between the control unit and the board pins; every output is registered.

Parameters:
- NUM_DIGITS, 4, number of 7-segment digits (1..8).
- LEDR_W, 10, red LED bank width.
- LEDG_W, 8, green LED bank width.
- BLINK_DIV, 25000000, clock cycles per blink half-period (>=2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  capture strobe for all data inputs
- led_red  in  LEDR_W  red LED pattern
- led_green  in  LEDG_W  green LED pattern
- led_red_blink  in  LEDR_W  per-bit blink enable, red bank
- hex_code  in  4*NUM_DIGITS  digit codes; digit i is bits [4i+3:4i]; digit 0 is least significant
- hex_off  in  NUM_DIGITS  per-digit force blank
- hex_blink  in  NUM_DIGITS  per-digit blink enable
- lz_en  in  1  leading-zero suppression enable
- LR  out  LEDR_W  red LED outputs, active-high
- LG  out  LEDG_W  green LED outputs, active-high
- HEX  out  7*NUM_DIGITS  segments, active-low; digit i is bits [7i+6:7i]; bit0=a … bit6=g
- blink_phase  out  1  current blink phase

Behaviour:
- Reset (async assert, sync release):
  - LR=0, LG=0, every HEX digit=7'h7F (blank), blink_phase=0, blink counter=0.
  - Shadow registers: all patterns 0, all hex_off=1, all blink enables 0, lz_en=0.
- Shadow capture:
  - On a rising edge with load=1, every data input (led_red … lz_en) is copied to its shadow.
  - With load=0 the shadows hold.
  - Outputs are decoded only from the shadows.
- Latency:
  - Outputs reflect a load at edge N on edge N+1.
  - Blink phase changes reflect on the edge after the phase toggles.
  - Exactly one register stage follows the shadow.
- Blink counter:
  - Counts 0..BLINK_DIV-1 and wraps to 0.
  - On the wrap edge blink_phase toggles.
  - Free-running; unaffected by load.
- LED output, per bit: LR[b] = shadow_red[b] & ~(shadow_red_blink[b] & blink_phase). LG = shadow_green; LG does not blink.
- Digit decode:
  - Standard hex glyphs, active-low: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- Digit blanking (output 7'h7F) when any of these holds:
  - hex_off[i]=1;
  - hex_blink[i]=1 and blink_phase=1;
  - lz_en=1, i>0, code[i]==0, and every digit j>i is either code 0 or off.
- Digit 0 is never zero-suppressed, so value 0 shows a single "0".
- Off digits above a zero do not stop suppression. A non-zero digit stops suppression for all digits below it.
- Simultaneous events:
  - load and blink wrap on the same edge: both take effect; the next output uses new data and the new phase.
  - load held high continuously: outputs track inputs with 1-cycle latency.
- Reset mid-operation: outputs blank or zero immediately, regardless of clk.

Optional Feature:
- Macro: DISPLAY_OUTPUT_DIM_EN.
- With the macro defined:
  - Extra input port brightness [3:0], captured into the shadows on load; reset value 4'hF.
  - A free-running 4-bit PWM counter is added.
  - Outputs are enabled when pwm_cnt < brightness, or when brightness == 4'hF (always on).
  - When not enabled: LR=0, LG=0, all HEX=7'h7F.
  - brightness=0 keeps the display dark.
- Without the macro: no brightness port, no PWM counter; outputs are always enabled as described above.

Test Plan:
- Reset, then release with no load: LR=0, LG=0, HEX all 7F; after BLINK_DIV cycles blink_phase=1.
- Load with hex_code=16'h1A3F, hex_off=0, lz_en=0: the next edge gives HEX digits 0..3 = 0E, 30, 08, 79.
- Load with hex_code=16'h0070, lz_en=1: digit3=7F, digit2=7F, digit1=78, digit0=40. Repeat with 16'h0000: only digit0=40.
- Load led_red=10'h3FF, led_red_blink=10'h001, hex_blink=4'b0001, BLINK_DIV=4: LR toggles between 3FF and 3FE, and digit0 toggles glyph/7F every 4 cycles. LG is unchanged throughout.
- Change inputs with load=0: outputs unchanged. Assert rst_n=0 mid-blink: outputs go to reset values asynchronously.
- With DISPLAY_OUTPUT_DIM_EN and brightness=4: over 16 cycles outputs are active exactly 4 cycles. brightness=0 gives always blank; F gives always on.
